sma_crossover_signal: RTL and testbench
=======================================

// Module: sma_crossover_signal
// PURPOSE
//   Downstream of the SMA stage. Consumes a fast and a slow moving average and their shared valid strobe.
//   Emits registered single-cycle buy/sell pulses when fast crosses slow, and tracks the resulting position.
//   Warm-up suppression and a post-trade cooldown prevent signals on partially filled windows and whipsaw.
// PARAMETERS
//   data_width  8  width of both SMA inputs (unsigned)
//   warmup      4  number of leading valid samples ignored after reset (set to slow window); 0 allowed
//   cooldown    3  valid samples after a buy/sell during which no new signal may fire; 0 allowed
//   threshold   2  hysteresis band in LSBs; only used when SMA_XOVER_HYST_EN is defined
// PORTS
//   clk         in   1           clock
//   rst         in   1           synchronous active-high reset
//   fast_in     in   data_width  fast SMA value
//   slow_in     in   data_width  slow SMA value
//   in_valid    in   1           fast_in/slow_in valid this cycle (upstream data_valid)
//   buy         out  1           1-cycle pulse: enter long
//   sell        out  1           1-cycle pulse: enter short
//   position    out  2           00 flat, 01 long, 10 short (11 never driven)
//   out_valid   out  1           registered copy of in_valid; buy/sell only assert with it
// BEHAVIOUR
//   - Reset: buy=0, sell=0, out_valid=0, position=00, FSM=WARMUP, warm-up/cooldown counters=0. Reset mid-operation is identical; any in-flight pulse is dropped.
//   - Latency: exactly 1 cycle. Sample on in_valid at edge N gives out_valid/buy/sell/position at edge N+1.
//   - in_valid=0: out_valid=0, buy=sell=0, FSM and counters hold, position holds.
//   - Compare (unsigned, in data_width+2 bits, no overflow): ABOVE if fast>slow, BELOW if fast<slow, else NONE.
//   - FSM states: WARMUP, FLAT, LONG, SHORT; advance only on in_valid.
//     WARMUP: first `warmup` valid samples are discarded (no pulses).
//       Sample number warmup+1 is evaluated as FLAT. If warmup=0, reset exits directly to FLAT.
//     FLAT : ABOVE -> LONG + buy; BELOW -> SHORT + sell; NONE -> FLAT.
//     LONG : BELOW -> SHORT + sell; else hold.  SHORT: ABOVE -> LONG + buy; else hold.
//   - Cooldown: on any pulse, load counter=cooldown.
//     While counter!=0, each valid sample decrements it; no transition and no pulse occur on that sample.
//   - buy and sell are never high together; position updates on the same edge as the pulse.
// CONFIGURATION
//   - SMA_XOVER_HYST_EN defined: ABOVE iff fast >= slow+threshold; BELOW iff slow >= fast+threshold; else NONE.
//   - Not defined: threshold ignored, plain strict compare as above.
// STRUCTURE
//   - Package sma_xover_pkg: typedef enum logic [1:0] xover_state_t {WARMUP,FLAT,LONG,SHORT};
//     position constants POS_FLAT/POS_LONG/POS_SHORT; typedef enum cmp_t {CMP_NONE,CMP_ABOVE,CMP_BELOW}.
//   - One sub-module: xover_cmp (combinational, parameterised data_width/threshold, returns cmp_t; holds the macro switch).
//   - Top: FSM, warm-up counter ($clog2(warmup+1) bits), cooldown counter ($clog2(cooldown+1) bits), output registers.
// TESTING (defaults warmup=4, cooldown=3, threshold=2)
//   1. Assert rst with in_valid=1, fast=200, slow=10 -> buy=sell=out_valid=0, position=00 every reset cycle.
//   2. After reset: 4 valid samples fast=10, slow=5 -> no pulse, position=00.
//      5th sample -> next cycle buy=1 for 1 cycle, position=01, out_valid=1.
//   3. From LONG (cooldown expired), fast=3, slow=8 -> sell pulse, position=10; repeat sample -> no pulse.
//   4. Cooldown: after buy, 3 valid samples fast=3, slow=8 -> no sell; 4th such sample -> sell.
//      Idle cycles (in_valid=0) in between do not decrement.
//   5. Hysteresis from FLAT: macro on: fast=9, slow=8 -> no pulse; then fast=10, slow=8 -> buy. Macro off: fast=9, slow=8 -> buy.
//   6. Reset mid-LONG: position->00, FSM WARMUP; next 4 valid ABOVE samples produce no buy, 5th produces buy.

Source files
------------

// File: rtl/sma_xover_pkg.sv
// ---------------------------------------------------------------------------
// sma_xover_pkg
//   Shared types and constants for the SMA crossover signal generator.
//   - xover_state_t : trading FSM states (WARMUP, FLAT, LONG, SHORT)
//   - cmp_t         : result of comparing the fast SMA against the slow SMA
//   - POS_*         : encodings driven on the 2-bit position output
//   - state_to_pos  : maps an FSM state onto the position encoding
// ---------------------------------------------------------------------------
package sma_xover_pkg;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        FLAT   = 2'd1,
        LONG   = 2'd2,
        SHORT  = 2'd3
    } xover_state_t;

    typedef enum logic [1:0] {
        CMP_NONE  = 2'd0,
        CMP_ABOVE = 2'd1,
        CMP_BELOW = 2'd2
    } cmp_t;

    localparam logic [1:0] POS_FLAT  = 2'b00;
    localparam logic [1:0] POS_LONG  = 2'b01;
    localparam logic [1:0] POS_SHORT = 2'b10;

    // While warming up we hold no position, so WARMUP reports flat.
    function automatic logic [1:0] state_to_pos(input xover_state_t s);
        logic [1:0] p;
        case (s)
            LONG:    p = POS_LONG;
            SHORT:   p = POS_SHORT;
            default: p = POS_FLAT;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/xover_cmp.sv
// ---------------------------------------------------------------------------
// xover_cmp
//   Purely combinational comparison of the fast SMA against the slow SMA.
//   Both operands are zero-extended by two bits so that adding the
//   hysteresis threshold can never wrap.
//
//   Configuration macro: SMA_XOVER_HYST_EN
//     defined   : ABOVE iff fast >= slow + threshold,
//                 BELOW iff slow >= fast + threshold, else NONE
//     undefined : plain strict compare, threshold is ignored
//
// Ports
//   fast_in  in   data_width  fast SMA value (unsigned)
//   slow_in  in   data_width  slow SMA value (unsigned)
//   cmp_out  out  cmp_t       CMP_ABOVE / CMP_BELOW / CMP_NONE
// ---------------------------------------------------------------------------
module xover_cmp
    import sma_xover_pkg::*;
#(
    parameter int data_width = 8,
    parameter int threshold  = 2
) (
    input  logic [data_width-1:0] fast_in,
    input  logic [data_width-1:0] slow_in,
    output cmp_t                  cmp_out
);

    localparam int EXT_W = data_width + 2;

    logic [EXT_W-1:0] fast_ext;
    logic [EXT_W-1:0] slow_ext;

    assign fast_ext = {2'b00, fast_in};
    assign slow_ext = {2'b00, slow_in};

`ifdef SMA_XOVER_HYST_EN
    logic [EXT_W-1:0] thr_ext;
    assign thr_ext = EXT_W'(threshold);

    // Hysteresis band: the averages must separate by at least threshold
    // LSBs before we call a direction. With threshold=0 equal inputs would
    // satisfy both tests, so ABOVE is given priority.
    always_comb begin
        cmp_out = CMP_NONE;
        if (fast_ext >= slow_ext + thr_ext) begin
            cmp_out = CMP_ABOVE;
        end else if (slow_ext >= fast_ext + thr_ext) begin
            cmp_out = CMP_BELOW;
        end
    end
`else
    // Strict compare: any difference at all is a direction.
    always_comb begin
        cmp_out = CMP_NONE;
        if (fast_ext > slow_ext) begin
            cmp_out = CMP_ABOVE;
        end else if (fast_ext < slow_ext) begin
            cmp_out = CMP_BELOW;
        end
    end
`endif

endmodule

// File: rtl/sma_crossover_signal.sv
// ---------------------------------------------------------------------------
// sma_crossover_signal
//   Turns a fast/slow moving-average pair into registered single-cycle buy
//   and sell pulses when the fast average crosses the slow one, and tracks
//   the resulting position. The first `warmup` valid samples after reset are
//   discarded, and after every trade `cooldown` valid samples are skipped to
//   suppress whipsaw. All outputs appear one cycle after the sample.
//
//   Configuration macro: SMA_XOVER_HYST_EN (enables the hysteresis band in
//   xover_cmp; see that file).
//
// Ports
//   clk        in   1           clock
//   rst        in   1           synchronous active-high reset
//   fast_in    in   data_width  fast SMA value
//   slow_in    in   data_width  slow SMA value
//   in_valid   in   1           fast_in/slow_in valid this cycle
//   buy        out  1           1-cycle pulse: enter long
//   sell       out  1           1-cycle pulse: enter short
//   position   out  2           00 flat, 01 long, 10 short
//   out_valid  out  1           registered copy of in_valid
// ---------------------------------------------------------------------------
module sma_crossover_signal
    import sma_xover_pkg::*;
#(
    parameter int data_width = 8,
    parameter int warmup     = 4,
    parameter int cooldown   = 3,
    parameter int threshold  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] fast_in,
    input  logic [data_width-1:0] slow_in,
    input  logic                  in_valid,
    output logic                  buy,
    output logic                  sell,
    output logic [1:0]            position,
    output logic                  out_valid
);

    // A zero-length window still needs a 1-bit counter to stay legal.
    localparam int WU_W = (warmup   > 0) ? $clog2(warmup + 1)   : 1;
    localparam int CD_W = (cooldown > 0) ? $clog2(cooldown + 1) : 1;

    localparam logic [WU_W-1:0] WU_LAST  = (warmup > 0) ? WU_W'(warmup - 1) : '0;
    localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(cooldown);

    // With no warm-up window the FSM leaves reset already in FLAT.
    localparam xover_state_t RESET_STATE = (warmup == 0) ? FLAT : WARMUP;

    xover_state_t    state_q,    state_d;
    logic [WU_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [CD_W-1:0] cool_cnt_q, cool_cnt_d;

    logic            buy_q,       buy_d;
    logic            sell_q,      sell_d;
    logic [1:0]      position_q,  position_d;
    logic            out_valid_q, out_valid_d;

    cmp_t            cmp;

    xover_cmp #(
        .data_width (data_width),
        .threshold  (threshold)
    ) u_cmp (
        .fast_in (fast_in),
        .slow_in (slow_in),
        .cmp_out (cmp)
    );

    // State register and both counters. Reset puts everything back to the
    // start of the warm-up window regardless of what was in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            warm_cnt_q <= '0;
            cool_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            cool_cnt_q <= cool_cnt_d;
        end
    end

    // Next-state logic. Nothing moves unless the current sample is valid.
    // In WARMUP the sample is only counted. Outside WARMUP an active
    // cooldown consumes the sample without looking at the compare result;
    // otherwise a crossing moves the FSM and re-arms the cooldown.
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        cool_cnt_d = cool_cnt_q;

        if (in_valid) begin
            if (state_q == WARMUP) begin
                warm_cnt_d = warm_cnt_q + 1'b1;
                if (warm_cnt_q == WU_LAST) begin
                    state_d = FLAT;
                end
            end else if (cool_cnt_q != '0) begin
                cool_cnt_d = cool_cnt_q - 1'b1;
            end else begin
                case (state_q)
                    FLAT: begin
                        if (cmp == CMP_ABOVE) begin
                            state_d    = LONG;
                            cool_cnt_d = CD_LOAD;
                        end else if (cmp == CMP_BELOW) begin
                            state_d    = SHORT;
                            cool_cnt_d = CD_LOAD;
                        end
                    end
                    LONG: begin
                        if (cmp == CMP_BELOW) begin
                            state_d    = SHORT;
                            cool_cnt_d = CD_LOAD;
                        end
                    end
                    SHORT: begin
                        if (cmp == CMP_ABOVE) begin
                            state_d    = LONG;
                            cool_cnt_d = CD_LOAD;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    // Output decode. LONG can only be entered through a buy and SHORT only
    // through a sell, so a pulse is simply "entering that state this sample".
    // Position follows the next state so it changes on the same edge as the
    // pulse that caused it.
    always_comb begin
        out_valid_d = in_valid;
        buy_d       = in_valid && (state_d == LONG)  && (state_q != LONG);
        sell_d      = in_valid && (state_d == SHORT) && (state_q != SHORT);
        position_d  = state_to_pos(state_d);
    end

    // Output registers give the fixed one-cycle latency; reset drops any
    // pulse that was about to be issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            buy_q       <= 1'b0;
            sell_q      <= 1'b0;
            position_q  <= POS_FLAT;
            out_valid_q <= 1'b0;
        end else begin
            buy_q       <= buy_d;
            sell_q      <= sell_d;
            position_q  <= position_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign buy       = buy_q;
    assign sell      = sell_q;
    assign position  = position_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sma_crossover_signal.sv
// ---------------------------------------------------------------------------
// tb_sma_crossover_signal
//   Self-checking bench for sma_crossover_signal. A behavioural model tracks
//   samples seen, cooldown remaining and the held position, and predicts the
//   outputs one cycle after each sample. Directed scenarios pin the model
//   with literal expectations, then a randomized phase runs against it.
//   Honours SMA_XOVER_HYST_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_sma_crossover_signal;

    localparam int DW        = 8;
    localparam int WARMUP_N  = 4;
    localparam int COOL_N    = 3;
    localparam int THR       = 2;

    logic          clk;
    logic          rst;
    logic [DW-1:0] fast_in;
    logic [DW-1:0] slow_in;
    logic          in_valid;
    logic          buy;
    logic          sell;
    logic [1:0]    position;
    logic          out_valid;

    int tests_run = 0;
    int tests_failed = 0;

    sma_crossover_signal #(
        .data_width (DW),
        .warmup     (WARMUP_N),
        .cooldown   (COOL_N),
        .threshold  (THR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fast_in   (fast_in),
        .slow_in   (slow_in),
        .in_valid  (in_valid),
        .buy       (buy),
        .sell      (sell),
        .position  (position),
        .out_valid (out_valid)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: positions are 0 flat, 1 long, 2 short.
    int   m_seen;
    int   m_cool;
    int   m_pos;
    logic e_buy, e_sell, e_valid;
    logic [1:0] e_pos;
    bit   model_live = 0;

    // Direction of the averages: 1 above, 2 below, 0 neither.
    function automatic int cmpModel(input int f, input int s);
`ifdef SMA_XOVER_HYST_EN
        if (f >= s + THR) return 1;
        if (s >= f + THR) return 2;
        return 0;
`else
        if (f > s) return 1;
        if (f < s) return 2;
        return 0;
`endif
    endfunction

    // Model update: one step per clock edge from the inputs held across it.
    always @(posedge clk) begin
        int c;
        model_live = 1;
        e_buy  = 1'b0;
        e_sell = 1'b0;
        if (rst) begin
            m_seen  = 0;
            m_cool  = 0;
            m_pos   = 0;
            e_valid = 1'b0;
        end else if (!in_valid) begin
            e_valid = 1'b0;
        end else begin
            e_valid = 1'b1;
            if (m_seen < WARMUP_N) begin
                m_seen++;
            end else if (m_cool > 0) begin
                m_cool--;
            end else begin
                c = cmpModel(int'(fast_in), int'(slow_in));
                if (c == 1 && m_pos != 1) begin
                    e_buy  = 1'b1;
                    m_pos  = 1;
                    m_cool = COOL_N;
                end else if (c == 2 && m_pos != 2) begin
                    e_sell = 1'b1;
                    m_pos  = 2;
                    m_cool = COOL_N;
                end
            end
        end
        e_pos = 2'(m_pos);
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            tests_run++;
            if (buy !== e_buy || sell !== e_sell || position !== e_pos || out_valid !== e_valid) begin
                tests_failed++;
                $display("[TB] FAIL cycle_compare t=%0t got buy=%b sell=%b pos=%b ov=%b want buy=%b sell=%b pos=%b ov=%b",
                         $time, buy, sell, position, out_valid, e_buy, e_sell, e_pos, e_valid);
            end
        end
    end

    // Drive one sample; it is captured at the following rising edge.
    task automatic applyStimulus(input logic r, input logic v, input int f, input int s);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        fast_in  = DW'(f);
        slow_in  = DW'(s);
    endtask

    // Literal check of both the DUT and the model just after the edge that
    // consumed the last applied sample.
    task automatic checkOutput(input string name, input logic eb, input logic es,
                               input logic [1:0] ep, input logic ev);
        @(posedge clk);
        #1;
        tests_run++;
        if (buy !== eb || sell !== es || position !== ep || out_valid !== ev) begin
            tests_failed++;
            $display("[TB] FAIL %s dut got buy=%b sell=%b pos=%b ov=%b want buy=%b sell=%b pos=%b ov=%b",
                     name, buy, sell, position, out_valid, eb, es, ep, ev);
        end
        tests_run++;
        if (e_buy !== eb || e_sell !== es || e_pos !== ep || e_valid !== ev) begin
            tests_failed++;
            $display("[TB] FAIL %s model got buy=%b sell=%b pos=%b ov=%b want buy=%b sell=%b pos=%b ov=%b",
                     name, e_buy, e_sell, e_pos, e_valid, eb, es, ep, ev);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        fast_in  = 8'd200;
        slow_in  = 8'd10;

        // Reset held with a strongly rising input must stay silent.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 200, 10);
            checkOutput("reset_hold", 1'b0, 1'b0, 2'b00, 1'b0);
        end

        // Warm-up samples are discarded, the fifth one buys.
        for (int i = 0; i < WARMUP_N; i++) begin
            applyStimulus(1'b0, 1'b1, 10, 5);
            checkOutput("warmup", 1'b0, 1'b0, 2'b00, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 10, 5);
        checkOutput("first_buy", 1'b1, 1'b0, 2'b01, 1'b1);

        applyStimulus(1'b0, 1'b0, 10, 5);
        checkOutput("idle_after_buy", 1'b0, 1'b0, 2'b01, 1'b0);

        // Cooldown: three valid falling samples are swallowed, idles in
        // between do not count, the fourth sells.
        applyStimulus(1'b0, 1'b1, 3, 8);
        checkOutput("cool_1", 1'b0, 1'b0, 2'b01, 1'b1);
        applyStimulus(1'b0, 1'b0, 3, 8);
        applyStimulus(1'b0, 1'b1, 3, 8);
        checkOutput("cool_2", 1'b0, 1'b0, 2'b01, 1'b1);
        applyStimulus(1'b0, 1'b0, 3, 8);
        applyStimulus(1'b0, 1'b0, 3, 8);
        applyStimulus(1'b0, 1'b1, 3, 8);
        checkOutput("cool_3", 1'b0, 1'b0, 2'b01, 1'b1);
        applyStimulus(1'b0, 1'b1, 3, 8);
        checkOutput("sell_after_cool", 1'b0, 1'b1, 2'b10, 1'b1);
        applyStimulus(1'b0, 1'b1, 3, 8);
        checkOutput("sell_repeat", 1'b0, 1'b0, 2'b10, 1'b1);

        // Hysteresis from FLAT after a fresh warm-up on equal inputs.
        applyStimulus(1'b1, 1'b1, 3, 8);
        checkOutput("reset_short", 1'b0, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < WARMUP_N; i++) begin
            applyStimulus(1'b0, 1'b1, 8, 8);
        end
        applyStimulus(1'b0, 1'b1, 9, 8);
`ifdef SMA_XOVER_HYST_EN
        checkOutput("hyst_inside_band", 1'b0, 1'b0, 2'b00, 1'b1);
        applyStimulus(1'b0, 1'b1, 10, 8);
        checkOutput("hyst_edge_buy", 1'b1, 1'b0, 2'b01, 1'b1);
`else
        checkOutput("strict_buy", 1'b1, 1'b0, 2'b01, 1'b1);
`endif

        // Reset mid-LONG restarts the warm-up window.
        applyStimulus(1'b1, 1'b1, 12, 3);
        checkOutput("reset_long", 1'b0, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < WARMUP_N; i++) begin
            applyStimulus(1'b0, 1'b1, 12, 3);
            checkOutput("rewarm", 1'b0, 1'b0, 2'b00, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 12, 3);
        checkOutput("rewarm_buy", 1'b1, 1'b0, 2'b01, 1'b1);

        // Randomized phase: mostly near-equal averages to provoke crossings,
        // with occasional full-range and extreme values and rare resets.
        for (int i = 0; i < 600; i++) begin
            int mode, base, f, s;
            logic r, v;
            r    = ($urandom_range(0, 99) < 2);
            v    = ($urandom_range(0, 9) < 7);
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                f = $urandom_range(0, 255);
                s = $urandom_range(0, 255);
            end else if (mode == 1) begin
                f = ($urandom_range(0, 1) == 1) ? 255 : 0;
                s = 255 - f;
            end else begin
                base = $urandom_range(0, 255);
                s = base;
                f = base + $urandom_range(0, 8) - 4;
                if (f < 0)   f = 0;
                if (f > 255) f = 255;
            end
            applyStimulus(r, v, f, s);
        end

        applyStimulus(1'b0, 1'b0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
